// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: A:B / S -> quotient in B, remainder in A.
// One shift cycle and one trial-subtract cycle per quotient bit.
module restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] S,
  input  logic             Run,
  input  logic             LoadA,
  input  logic             LoadB,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             X,
  output logic             Busy
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] SUB   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             x_q, x_d;

  logic [WIDTH-1:0] diff;
  logic             no_borrow;
  logic             last;

  // Low bits of {C,A}-{0,D} equal A-D; the borrow comes from the wide compare.
  assign diff      = a_q - d_q;
  assign no_borrow = {c_q, a_q} >= {1'b0, d_q};
  assign last      = cnt_q == CW'(WIDTH - 1);

  // Next-state and datapath decode for the four-state sequencer.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    d_d     = d_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    unique case (state_q)
      IDLE: begin
        if (LoadA || LoadB) begin
          if (LoadA) a_d = S;
          if (LoadB) b_d = S;
        end else if (Run) begin
          if ((S == '0) || (a_q >= S)) begin
            x_d     = 1'b1;
            state_d = DONE;
          end else begin
            x_d     = 1'b0;
            d_d     = S;
            cnt_d   = '0;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        {c_d, a_d, b_d} = {a_q, b_q, 1'b0};
        state_d = SUB;
      end
      SUB: begin
        if (no_borrow) begin
          a_d    = diff;
          b_d[0] = 1'b1;
        end
        c_d     = 1'b0;
        cnt_d   = cnt_q + CW'(1);
        state_d = last ? DONE : SHIFT;
      end
      DONE: begin
        if (!Run) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      x_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      d_q     <= d_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
    end
  end

  assign Aval = a_q;
  assign Bval = b_q;
  assign X    = x_q;
  assign Busy = (state_q == SHIFT) || (state_q == SUB);

endmodule

// File: tb/tb_restoring_divider.sv
// Scoreboard bench for restoring_divider: stimulus queues expectations,
// a negedge monitor pops them when a result appears.
module tb_restoring_divider;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] S = '0;
  logic       Run = 1'b0;
  logic       LoadA = 1'b0;
  logic       LoadB = 1'b0;
  logic [7:0] Aval, Bval;
  logic       X, Busy;

  logic chk_req = 1'b0;

  typedef struct {
    string      name;
    logic [7:0] a;
    logic [7:0] b;
    logic       x;
    int         busy;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt = 0;
  int   total = 0;

  restoring_divider #(.WIDTH(8)) dut (
    .Clk(Clk), .Reset(Reset), .S(S), .Run(Run),
    .LoadA(LoadA), .LoadB(LoadB),
    .Aval(Aval), .Bval(Bval), .X(X), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act == req) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  // Monitor: a result is present when Busy falls or stimulus flags one.
  initial begin
    int   bcnt;
    logic prev_busy;
    exp_t e;
    bcnt = 0;
    prev_busy = 1'b0;
    forever begin
      @(negedge Clk);
      if (Busy === 1'b1) bcnt++;
      if ((prev_busy === 1'b1 && Busy === 1'b0) || chk_req) begin
        if (sb.size() == 0) begin
          total++;
          $display("FAIL unexpected_result A=%h B=%h X=%b required=none",
                   Aval, Bval, X);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_A"}, int'(Aval), int'(e.a));
          chk({e.name, "_B"}, int'(Bval), int'(e.b));
          chk({e.name, "_X"}, int'(X), int'(e.x));
          if (e.busy >= 0) chk({e.name, "_busy"}, bcnt, e.busy);
        end
        bcnt = 0;
      end
      prev_busy = Busy;
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push(input string n, input logic [7:0] a,
                      input logic [7:0] b, input logic x, input int bz);
    exp_t e;
    e.name = n; e.a = a; e.b = b; e.x = x; e.busy = bz;
    sb.push_back(e);
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] s);
    S = a; LoadA = 1'b1;
    tick();
    LoadA = 1'b0; S = b; LoadB = 1'b1;
    tick();
    LoadB = 1'b0; S = s;
  endtask

  task automatic drain(input string n);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 200) begin
      tick();
      k++;
    end
    if (sb.size() != 0) begin
      total++;
      $display("FAIL timeout_%s pending=%0d required=0", n, sb.size());
      sb.delete();
    end
    repeat (2) tick();
  endtask

  // Pulse Run for one edge; error results are flagged to the monitor.
  task automatic start(input string n, input logic [7:0] a,
                       input logic [7:0] b, input logic x,
                       input int bz, input bit err);
    push(n, a, b, x, bz);
    Run = 1'b1;
    tick();
    Run = 1'b0;
    if (err) chk_req = 1'b1;
    tick();
    chk_req = 1'b0;
    drain(n);
  endtask

  initial begin
    repeat (2) tick();
    Reset = 1'b0;
    push("reset", 8'h00, 8'h00, 1'b0, 0);
    chk_req = 1'b1;
    tick();
    chk_req = 1'b0;
    tick();

    load(8'h00, 8'hC8, 8'h07);
    start("basic", 8'h04, 8'h1C, 1'b0, 16, 1'b0);

    load(8'h03, 8'hE8, 8'h0A);
    start("exact", 8'h00, 8'h64, 1'b0, 16, 1'b0);

    load(8'hFE, 8'hFF, 8'hFF);
    start("max", 8'hFE, 8'hFF, 1'b0, 16, 1'b0);

    load(8'h05, 8'h33, 8'h05);
    start("err_ovf", 8'h05, 8'h33, 1'b1, 0, 1'b1);

    S = 8'h00;
    start("err_zero", 8'h05, 8'h33, 1'b1, 0, 1'b1);

    // Load and Run together: load wins, no division starts.
    push("load_prio", 8'h10, 8'h33, 1'b1, 0);
    S = 8'h10; LoadA = 1'b1; Run = 1'b1;
    tick();
    LoadA = 1'b0; Run = 1'b0; chk_req = 1'b1;
    tick();
    chk_req = 1'b0;
    drain("load_prio");

    // Run held 40 cycles with a LoadA attempt mid-division.
    load(8'h00, 8'hC8, 8'h07);
    push("hold", 8'h04, 8'h1C, 1'b0, 16);
    Run = 1'b1;
    tick();
    repeat (2) tick();
    S = 8'h55; LoadA = 1'b1;
    tick();
    LoadA = 1'b0; S = 8'h07;
    repeat (36) tick();
    Run = 1'b0;
    drain("hold");

    // 0x041C / 5 = 210 rem 2
    S = 8'h05;
    start("rerun", 8'h02, 8'hD2, 1'b0, 16, 1'b0);

    // Reset during the fifth Busy cycle.
    load(8'h03, 8'hE8, 8'h0A);
    push("reset_mid", 8'h00, 8'h00, 1'b0, 5);
    Run = 1'b1;
    tick();
    Run = 1'b0;
    repeat (4) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    drain("reset_mid");

    load(8'h03, 8'hE8, 8'h0A);
    start("after_reset", 8'h00, 8'h64, 1'b0, 16, 1'b0);

    repeat (3) tick();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
